dual_issue_dispatch: RTL and testbench
======================================

DUAL_ISSUE_DISPATCH -- requirements
Module: dual_issue_dispatch

Interface
REQ-001 SHALL have parameter REG_AW, default 7, the register-address width (128-entry register file).
REQ-002 SHALL have parameter PC_W, default 32, the program-counter width.
REQ-003 SHALL have one clock and an asynchronous active-low reset; signals follow.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  decoded instruction pair presented.
REQ-007 in_ready  out  1  pair accepted on a clk edge where in_valid&in_ready.
REQ-008 in_pc  in  PC_W  address of op0; op1 is at in_pc+4.
REQ-009 in_op0, in_op1  in  7 each  opcode enum; op0 is the older instruction.
REQ-010 in_rt0/ra0/rb0/rc0, in_rt1/ra1/rb1/rc1  in  REG_AW each  destination and sources.
REQ-011 stall  in  1  downstream back-pressure; holds issue registers.
REQ-012 flush  in  1  synchronous squash from branch resolution.
REQ-013 ev_valid, ev_op, ev_rt, ev_ra, ev_rb, ev_rc, ev_pc  out  1/7/REG_AW x4/PC_W  even-pipe issue slot.
REQ-014 od_valid, od_op, od_rt, od_ra, od_rb, od_rc, od_pc  out  same widths  odd-pipe issue slot.

Function
REQ-015 SHALL classify opcodes 67..92 and 94 as ODD pipe; all others, including 93 (nop execute) and undefined 0, SHALL be EVEN.
REQ-016 SHALL hold one accepted pair in a buffer; states EMPTY, FULL (pair held, none issued), SECOND (op0 issued, op1 pending).
REQ-017 Pair is dual-issuable iff pipe(op0)!=pipe(op1) and rt0 differs from ra1, rb1, rc1 and rt1 (conservative; all fields compared regardless of opcode).
REQ-018 On a non-stall, non-flush edge in FULL: dual-issuable -> both ops load their pipe slots, state EMPTY; otherwise op0 loads its pipe slot, other slot valid=0, state SECOND.
REQ-019 On a non-stall, non-flush edge in SECOND: op1 loads its pipe slot, other slot valid=0, state EMPTY.
REQ-020 in_ready SHALL be combinational: !stall & !flush & (EMPTY | SECOND | (FULL & dual-issuable)); an accept in the same edge as the buffer drains reloads it, state FULL.
REQ-021 Accept-to-issue latency SHALL be one edge after the accepting edge for op0; throughput one pair per cycle when every pair is dual-issuable.
REQ-022 Non-flush edge with stall=1: issue registers, buffer and state SHALL hold.
REQ-023 Non-stall edge with nothing to issue (EMPTY, no accept) SHALL clear ev_valid and od_valid.
REQ-024 flush=1 SHALL, on that edge, clear ev_valid, od_valid and the buffer and force EMPTY; flush overrides stall and in_valid.
REQ-025 Slot pc SHALL be in_pc for op0, in_pc+4 for op1 (mod 2^PC_W).
REQ-026 ev_valid and od_valid SHALL never be high for two ops of the same pipe; ops SHALL issue in program order.

Reset
REQ-027 While rst_n=0: state EMPTY, buffer cleared, ev_valid=od_valid=0, all slot data outputs 0; in_ready deasserted during reset.
REQ-028 Reset assertion mid-pair SHALL discard buffered instructions with no partial issue after release.

Configuration
REQ-029 Macro DUAL_ISSUE_EN defined: behaviour per REQ-017/018.
REQ-030 DUAL_ISSUE_EN undefined: every pair SHALL be treated as not dual-issuable (always FULL->SECOND->EMPTY); interface unchanged.

Structure
REQ-031 Shared package SHALL hold pipe_of() classification function, the dispatch state enum and an issue-slot struct (op, rt, ra, rb, rc, pc); the opcode enum and EVEN/ODD constants remain in the existing descriptions package.
REQ-032 One sub-module pair_check (combinational: pipe classes, dependency compare, dual-issuable flag) SHALL be instantiated.

Verification
REQ-033 op0=ADD_WORD(1) rt0=5, op1=LOAD_QUADWORD_AFORM(81) ra1=6 -> next edge ev_op=1, od_op=81, both valid, od_pc=in_pc+4.
REQ-034 Same pair with ra1=5 -> edge 1 ev_valid only (op 1); edge 2 od_valid only (op 81); in_ready low during FULL.
REQ-035 op0=ADD(13), op1=OR(17), independent regs -> ev_op=13 then ev_op=17 on consecutive edges, od_valid=0 both.
REQ-036 stall=1 for 3 cycles while FULL -> outputs, state unchanged; release -> issue per REQ-018.
REQ-037 flush=1 in SECOND with stall=1 -> next edge both valids 0, state EMPTY, op1 never issued.
REQ-038 Build without DUAL_ISSUE_EN, REQ-033 stimulus -> split issue over two edges.

Source files
------------

// File: rtl/dual_issue_dispatch_pkg.sv
// Dispatch-local types: pipe classification, dispatch state and the
// issue-slot record. Slot field widths bound the REG_AW / PC_W parameters
// of dual_issue_dispatch.
package dual_issue_dispatch_pkg;
  import spu_desc_pkg::*;

  localparam int SLOT_REG_AW = 7;
  localparam int SLOT_PC_W   = 32;

  typedef logic [6:0] op_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SECOND
  } dispatch_state_e;

  typedef struct packed {
    op_t                    op;
    logic [SLOT_REG_AW-1:0] rt;
    logic [SLOT_REG_AW-1:0] ra;
    logic [SLOT_REG_AW-1:0] rb;
    logic [SLOT_REG_AW-1:0] rc;
    logic [SLOT_PC_W-1:0]   pc;
  } issue_slot_t;

  // Odd pipe: 67..92 plus 94; everything else (93 and undefined 0 too) is even.
  function automatic logic pipe_of(input op_t op);
    if ((op >= OP_ODD_FIRST && op <= OP_ODD_LAST) || op == OP_NOP_LOAD)
      return PIPE_ODD;
    return PIPE_EVEN;
  endfunction

endpackage

// File: rtl/spu_desc_pkg.sv
// Instruction descriptions shared across the SPU front end: opcode
// encodings and the even/odd execution-pipe identifiers.
package spu_desc_pkg;

  // Opcodes referenced by dispatch; the remaining 7-bit codes exist but
  // need no name here.
  typedef enum logic [6:0] {
    OP_UNDEF               = 7'd0,
    OP_ADD_WORD            = 7'd1,
    OP_ADD                 = 7'd13,
    OP_OR                  = 7'd17,
    OP_ODD_FIRST           = 7'd67,
    OP_LOAD_QUADWORD_AFORM = 7'd81,
    OP_ODD_LAST            = 7'd92,
    OP_NOP_EXECUTE         = 7'd93,
    OP_NOP_LOAD            = 7'd94
  } opcode_e;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

endpackage

// File: rtl/dual_issue_dispatch_pair_check.sv
// Combinational pair check: pipe class of each op and whether the pair can
// issue together (different pipes, no register overlap on op0's target).
module pair_check
  import dual_issue_dispatch_pkg::*;
#(
  parameter int REG_AW = 7
) (
  input  op_t               op0,
  input  op_t               op1,
  input  logic [REG_AW-1:0] rt0,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] rb1,
  input  logic [REG_AW-1:0] rc1,
  input  logic [REG_AW-1:0] rt1,
  output logic              pipe0,
  output logic              pipe1,
  output logic              dual_issuable
);

  logic dep_hazard;

  assign pipe0 = pipe_of(op0);
  assign pipe1 = pipe_of(op1);

  // Compared regardless of whether op1 actually reads each field.
  assign dep_hazard = (rt0 == ra1) || (rt0 == rb1) || (rt0 == rc1) || (rt0 == rt1);

  assign dual_issuable = (pipe0 != pipe1) && !dep_hazard;

endmodule

// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: holds one decoded pair and issues it to the even and
// odd pipe slots, together when independent, otherwise over two edges in
// program order. Define DUAL_ISSUE_EN to allow pairing; without it every
// pair issues split.
module dual_issue_dispatch
  import spu_desc_pkg::*, dual_issue_dispatch_pkg::*;
#(
  parameter int REG_AW = 7,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [6:0]        in_op0,
  input  logic [6:0]        in_op1,
  input  logic [REG_AW-1:0] in_rt0,
  input  logic [REG_AW-1:0] in_ra0,
  input  logic [REG_AW-1:0] in_rb0,
  input  logic [REG_AW-1:0] in_rc0,
  input  logic [REG_AW-1:0] in_rt1,
  input  logic [REG_AW-1:0] in_ra1,
  input  logic [REG_AW-1:0] in_rb1,
  input  logic [REG_AW-1:0] in_rc1,
  input  logic              stall,
  input  logic              flush,
  output logic              ev_valid,
  output logic [6:0]        ev_op,
  output logic [REG_AW-1:0] ev_rt,
  output logic [REG_AW-1:0] ev_ra,
  output logic [REG_AW-1:0] ev_rb,
  output logic [REG_AW-1:0] ev_rc,
  output logic [PC_W-1:0]   ev_pc,
  output logic              od_valid,
  output logic [6:0]        od_op,
  output logic [REG_AW-1:0] od_rt,
  output logic [REG_AW-1:0] od_ra,
  output logic [REG_AW-1:0] od_rb,
  output logic [REG_AW-1:0] od_rc,
  output logic [PC_W-1:0]   od_pc
);

  dispatch_state_e state;
  issue_slot_t     buf0, buf1;
  issue_slot_t     in_slot0, in_slot1;
  issue_slot_t     ev_q, od_q;
  logic            ev_v, od_v;
  logic [PC_W-1:0] pc1;
  logic            pipe0, pipe1, pair_dual, dual_issuable;
  logic            accept;

  pair_check #(.REG_AW(REG_AW)) u_pair_check (
    .op0           (buf0.op),
    .op1           (buf1.op),
    .rt0           (buf0.rt[REG_AW-1:0]),
    .ra1           (buf1.ra[REG_AW-1:0]),
    .rb1           (buf1.rb[REG_AW-1:0]),
    .rc1           (buf1.rc[REG_AW-1:0]),
    .rt1           (buf1.rt[REG_AW-1:0]),
    .pipe0         (pipe0),
    .pipe1         (pipe1),
    .dual_issuable (pair_dual)
  );

`ifdef DUAL_ISSUE_EN
  assign dual_issuable = pair_dual;
`else
  // Pair check stays in place so both builds share the same datapath.
  assign dual_issuable = 1'b0 & pair_dual;
`endif

  // A new pair fits whenever the buffer drains (or is already empty) this edge.
  assign in_ready = rst_n && !stall && !flush &&
                    (state == ST_EMPTY || state == ST_SECOND ||
                     (state == ST_FULL && dual_issuable));
  assign accept   = in_valid && in_ready;

  assign pc1 = in_pc + PC_W'(4);

  // Pack the incoming pair into slot records; op1 sits at the next word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    in_slot0    = '0;
    in_slot1    = '0;
    in_slot0.op = in_op0;
    in_slot0.rt = SLOT_REG_AW'(in_rt0);
    in_slot0.ra = SLOT_REG_AW'(in_ra0);
    in_slot0.rb = SLOT_REG_AW'(in_rb0);
    in_slot0.rc = SLOT_REG_AW'(in_rc0);
    in_slot0.pc = SLOT_PC_W'(in_pc);
    in_slot1.op = in_op1;
    in_slot1.rt = SLOT_REG_AW'(in_rt1);
    in_slot1.ra = SLOT_REG_AW'(in_ra1);
    in_slot1.rb = SLOT_REG_AW'(in_rb1);
    in_slot1.rc = SLOT_REG_AW'(in_rc1);
    in_slot1.pc = SLOT_PC_W'(pc1);
  end

  // Dispatch FSM: drains the buffer into the pipe slots and refills it on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the pair buffer is reset along with the slots so a half-issued pair can never leak out after reset.
      state <= ST_EMPTY;
      buf0  <= '0;
      buf1  <= '0;
      ev_q  <= '0;
      od_q  <= '0;
      ev_v  <= 1'b0;
      od_v  <= 1'b0;
    end else if (flush) begin
      state <= ST_EMPTY;
      buf0  <= '0;
      buf1  <= '0;
      ev_v  <= 1'b0;
      od_v  <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking updates; a later assignment in this block overrides an earlier default for the same edge.
      ev_v <= 1'b0;
      od_v <= 1'b0;
      case (state)
        ST_FULL: begin
          if (pipe0 == PIPE_ODD) begin
            od_q <= buf0;
            od_v <= 1'b1;
          end else begin
            ev_q <= buf0;
            ev_v <= 1'b1;
          end
          if (dual_issuable) begin
            // Pipes differ, so op1 lands in the slot op0 left free.
            if (pipe1 == PIPE_ODD) begin
              od_q <= buf1;
              od_v <= 1'b1;
            end else begin
              ev_q <= buf1;
              ev_v <= 1'b1;
            end
            state <= ST_EMPTY;
          end else begin
            state <= ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (pipe1 == PIPE_ODD) begin
            od_q <= buf1;
            od_v <= 1'b1;
          end else begin
            ev_q <= buf1;
            ev_v <= 1'b1;
          end
          state <= ST_EMPTY;
        end
        default: ;
      endcase
      if (accept) begin
        buf0  <= in_slot0;
        buf1  <= in_slot1;
        state <= ST_FULL;
      end
    end
  end

  assign ev_valid = ev_v;
  assign ev_op    = ev_q.op;
  assign ev_rt    = ev_q.rt[REG_AW-1:0];
  assign ev_ra    = ev_q.ra[REG_AW-1:0];
  assign ev_rb    = ev_q.rb[REG_AW-1:0];
  assign ev_rc    = ev_q.rc[REG_AW-1:0];
  assign ev_pc    = ev_q.pc[PC_W-1:0];
  assign od_valid = od_v;
  assign od_op    = od_q.op;
  assign od_rt    = od_q.rt[REG_AW-1:0];
  assign od_ra    = od_q.ra[REG_AW-1:0];
  assign od_rb    = od_q.rb[REG_AW-1:0];
  assign od_rc    = od_q.rc[REG_AW-1:0];
  assign od_pc    = od_q.pc[PC_W-1:0];

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Bench for dual_issue_dispatch: a table of pairs with hand-derived pairing
// outcomes, an issue scoreboard, and hand-written stall/flush/reset sequences.
// Honours DUAL_ISSUE_EN the same way the design does.
module tb_dual_issue_dispatch;

`ifdef DUAL_ISSUE_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [6:0]  in_op0, in_op1;
  logic [6:0]  in_rt0, in_ra0, in_rb0, in_rc0, in_rt1, in_ra1, in_rb1, in_rc1;
  logic        stall, flush;
  logic        ev_valid, od_valid;
  logic [6:0]  ev_op, ev_rt, ev_ra, ev_rb, ev_rc;
  logic [6:0]  od_op, od_rt, od_ra, od_rb, od_rc;
  logic [31:0] ev_pc, od_pc;

  dual_issue_dispatch #(.REG_AW(7), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_op0(in_op0), .in_op1(in_op1),
    .in_rt0(in_rt0), .in_ra0(in_ra0), .in_rb0(in_rb0), .in_rc0(in_rc0),
    .in_rt1(in_rt1), .in_ra1(in_ra1), .in_rb1(in_rb1), .in_rc1(in_rc1),
    .stall(stall), .flush(flush),
    .ev_valid(ev_valid), .ev_op(ev_op), .ev_rt(ev_rt), .ev_ra(ev_ra),
    .ev_rb(ev_rb), .ev_rc(ev_rc), .ev_pc(ev_pc),
    .od_valid(od_valid), .od_op(od_op), .od_rt(od_rt), .od_ra(od_ra),
    .od_rb(od_rb), .od_rc(od_rc), .od_pc(od_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op0, op1;
    logic [6:0]  rt0, ra1, rb1, rc1, rt1;
    logic [31:0] pc;
    bit          dual;   // pairable when dual issue is enabled
  } vec_t;

  typedef struct packed {
    bit          ev_v;
    logic [6:0]  ev_op, ev_rt;
    logic [31:0] ev_pc;
    bit          od_v;
    logic [6:0]  od_op, od_rt;
    logic [31:0] od_pc;
  } exp_t;

  exp_t exp_q[$];
  int   num_checks = 0;
  int   num_errors = 0;
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit tb_odd(input logic [6:0] op);
    return (op >= 7'd67 && op <= 7'd92) || op == 7'd94;
  endfunction

  function automatic exp_t add_op(input exp_t e, input logic [6:0] op,
                                  input logic [6:0] rt, input logic [31:0] pc);
    exp_t r = e;
    if (tb_odd(op)) begin
      r.od_v = 1'b1; r.od_op = op; r.od_rt = rt; r.od_pc = pc;
    end else begin
      r.ev_v = 1'b1; r.ev_op = op; r.ev_rt = rt; r.ev_pc = pc;
    end
    return r;
  endfunction

  task automatic push_expect(input vec_t v, input bit with_op1);
    exp_t e0 = '0;
    exp_t e1 = '0;
    e0 = add_op(e0, v.op0, v.rt0, v.pc);
    if (DUAL_EN && v.dual) begin
      e0 = add_op(e0, v.op1, v.rt1, v.pc + 32'd4);
      exp_q.push_back(e0);
    end else begin
      exp_q.push_back(e0);
      if (with_op1) begin
        e1 = add_op(e1, v.op1, v.rt1, v.pc + 32'd4);
        exp_q.push_back(e1);
      end
    end
  endtask

  task automatic drive(input vec_t v);
    in_pc  = v.pc;
    in_op0 = v.op0; in_op1 = v.op1;
    in_rt0 = v.rt0; in_ra0 = 7'd0; in_rb0 = 7'd0; in_rc0 = 7'd0;
    in_rt1 = v.rt1; in_ra1 = v.ra1; in_rb1 = v.rb1; in_rc1 = v.rc1;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send_pair(input vec_t v, input bit with_op1);
    int waited = 0;
    drive(v);
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1);
    push_expect(v, with_op1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard: every edge that is not held by stall and shows a valid slot
  // must match the next expected issue group.
  bit   edge_held;
  exp_t got_e;
  always @(posedge clk) begin
    edge_held = stall && !flush;
    #1;
    if (rst_n && !edge_held && (ev_valid || od_valid)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_issue", {ev_valid, od_valid}, 0);
      end else begin
        got_e = exp_q.pop_front();
        check("sb_ev_valid", ev_valid, got_e.ev_v);
        check("sb_od_valid", od_valid, got_e.od_v);
        if (got_e.ev_v) begin
          check("sb_ev_op", ev_op, got_e.ev_op);
          check("sb_ev_rt", ev_rt, got_e.ev_rt);
          check("sb_ev_pc", ev_pc, got_e.ev_pc);
        end
        if (got_e.od_v) begin
          check("sb_od_op", od_op, got_e.od_op);
          check("sb_od_rt", od_rt, got_e.od_rt);
          check("sb_od_pc", od_pc, got_e.od_pc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t pa, pb;
    int   waited;

    //            op0     op1     rt0    ra1    rb1    rc1    rt1    pc             dual
    vecs[0]  = '{7'd1,  7'd81, 7'd5,  7'd6,  7'd7,  7'd8,  7'd9,  32'h0000_1000, 1'b1};
    vecs[1]  = '{7'd1,  7'd81, 7'd5,  7'd5,  7'd7,  7'd8,  7'd9,  32'h0000_1010, 1'b0};
    vecs[2]  = '{7'd13, 7'd17, 7'd3,  7'd10, 7'd11, 7'd12, 7'd14, 32'h0000_1020, 1'b0};
    vecs[3]  = '{7'd1,  7'd81, 7'd20, 7'd21, 7'd20, 7'd22, 7'd23, 32'h0000_1030, 1'b0};
    vecs[4]  = '{7'd1,  7'd81, 7'd30, 7'd31, 7'd32, 7'd30, 7'd33, 32'h0000_1040, 1'b0};
    vecs[5]  = '{7'd1,  7'd81, 7'd40, 7'd41, 7'd42, 7'd43, 7'd40, 32'h0000_1050, 1'b0};
    vecs[6]  = '{7'd81, 7'd1,  7'd50, 7'd51, 7'd52, 7'd53, 7'd54, 32'h0000_1060, 1'b1};
    vecs[7]  = '{7'd67, 7'd66, 7'd60, 7'd61, 7'd62, 7'd63, 7'd64, 32'h0000_1070, 1'b1};
    vecs[8]  = '{7'd92, 7'd93, 7'd70, 7'd71, 7'd72, 7'd73, 7'd74, 32'h0000_1080, 1'b1};
    vecs[9]  = '{7'd94, 7'd0,  7'd80, 7'd81, 7'd82, 7'd83, 7'd84, 32'h0000_1090, 1'b1};
    vecs[10] = '{7'd93, 7'd0,  7'd90, 7'd91, 7'd92, 7'd93, 7'd94, 32'h0000_10a0, 1'b0};
    vecs[11] = '{7'd67, 7'd94, 7'd100,7'd101,7'd102,7'd103,7'd104,32'h0000_10b0, 1'b0};
    vecs[12] = '{7'd1,  7'd81, 7'd110,7'd111,7'd112,7'd113,7'd114,32'hffff_fffc, 1'b1};
    vecs[13] = '{7'd95, 7'd68, 7'd120,7'd121,7'd122,7'd123,7'd124,32'h0000_10c0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_od_valid", od_valid, 0);
    check("rst_ev_op", ev_op, 0);
    check("rst_od_pc", od_pc, 0);
    check("rst_ev_rt", ev_rt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);

    // Table: one pair at a time, drained fully before the next.
    for (int i = 0; i < 14; i++) begin
      send_pair(vecs[i], 1'b1);
      check($sformatf("full_ready_%0d", i), in_ready, DUAL_EN && vecs[i].dual);
      @(negedge clk);
      check($sformatf("issue_latency_%0d", i), ev_valid || od_valid, 1);
      repeat (2) @(negedge clk);
      check($sformatf("idle_clear_%0d", i), {ev_valid, od_valid}, 0);
    end

    // Back-to-back pairable pairs: next pair accepted on the very next edge.
    pa = '{7'd1,  7'd81, 7'd5,  7'd6,  7'd7,  7'd8,  7'd9,  32'h0000_2000, 1'b1};
    pb = '{7'd81, 7'd13, 7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 32'h0000_2008, 1'b1};
    drive(pa);
    in_valid = 1'b1;
    check("b2b_ready0", in_ready, 1);
    push_expect(pa, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(pb);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("b2b_accept_gap", 64'(waited), DUAL_EN ? 64'd0 : 64'd1);
    push_expect(pb, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_idle", {ev_valid, od_valid}, 0);

    // Stall for three edges while FULL, then again while SECOND.
    send_pair(vecs[1], 1'b1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_full_valids", {ev_valid, od_valid}, 0);
      check("stall_full_ready", in_ready, 0);
    end
    stall = 1'b0;
    @(negedge clk);
    check("stall_rel_ev_valid", ev_valid, 1);
    check("stall_rel_ev_op", ev_op, 1);
    check("stall_rel_od_valid", od_valid, 0);
    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_second_hold", {ev_valid, ev_op, od_valid}, {1'b1, 7'd1, 1'b0});
    end
    stall = 1'b0;
    @(negedge clk);
    check("second_od_valid", od_valid, 1);
    check("second_od_op", od_op, 81);
    check("second_ev_valid", ev_valid, 0);
    @(negedge clk);
    check("after_second_idle", {ev_valid, od_valid}, 0);

    // Flush in SECOND with stall high: op1 is squashed.
    send_pair(vecs[2], 1'b0);
    @(negedge clk);
    check("flush_pre_ev", {ev_valid, ev_op}, {1'b1, 7'd13});
    flush = 1'b1; stall = 1'b1;
    drive(pa);
    in_valid = 1'b1;
    #1;
    check("flush_ready", in_ready, 0);
    @(negedge clk);
    check("flush_valids", {ev_valid, od_valid}, 0);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_empty_ready", in_ready, 1);
    repeat (2) begin
      @(negedge clk);
      check("flush_no_op1", {ev_valid, od_valid}, 0);
    end

    // Reset mid-pair: op1 must never appear after release.
    send_pair(vecs[1], 1'b0);
    @(negedge clk);
    check("rstmid_op0", {ev_valid, ev_op}, {1'b1, 7'd1});
    rst_n = 1'b0;
    #1;
    check("rstmid_valids", {ev_valid, od_valid}, 0);
    check("rstmid_ev_op", ev_op, 0);
    check("rstmid_ev_pc", ev_pc, 0);
    check("rstmid_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_op1", {ev_valid, od_valid}, 0);
    end

    check("sb_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
